// File: rtl/rv32i_lsu_pkg.sv
// RV32I load/store funct3 encodings, bridge FSM states and access legality check.
package rv32i_lsu_pkg;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;
  localparam logic [2:0] F3_SB  = 3'd0;
  localparam logic [2:0] F3_SH  = 3'd1;
  localparam logic [2:0] F3_SW  = 3'd2;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR      = 3'd1,
    ST_RD_ADDR = 3'd2,
    ST_RD_DATA = 3'd3,
    ST_RESP    = 3'd4
  } lsu_state_e;

  // funct3[1:0] gives the access size for every legal code: 0 byte, 1 half, 2 word.
  function automatic logic lsu_illegal(input logic we, input logic [2:0] funct3,
                                       input logic [1:0] addr_lo);
    logic bad;
    if (we) bad = (funct3 != F3_SB) && (funct3 != F3_SH) && (funct3 != F3_SW);
    else    bad = (funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7);
    if ((funct3[1:0] == 2'd1) && addr_lo[0])        bad = 1'b1;
    if ((funct3[1:0] == 2'd2) && (addr_lo != 2'd0)) bad = 1'b1;
    return bad;
  endfunction

endpackage

// File: rtl/lsu_axi_bridge_if.sv
// Core request/response and user write/read port signals of the LSU bridge.
interface lsu_axi_bridge_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 8,
  parameter int STRB_WIDTH = 4
);
  logic                  c_req;
  logic                  c_we;
  logic [2:0]            c_funct3;
  logic [ADDR_WIDTH-1:0] c_addr;
  logic [DATA_WIDTH-1:0] c_wdata;
  logic                  c_ready;
  logic                  c_done;
  logic                  c_err;
  logic [DATA_WIDTH-1:0] c_rdata;

  logic                  u_wr_req;
  logic [LEN_WIDTH-1:0]  u_wr_len;
  logic [ADDR_WIDTH-1:0] u_wr_addr;
  logic [DATA_WIDTH-1:0] u_wr_data;
  logic [STRB_WIDTH-1:0] u_wr_strb;
  logic                  u_wr_gnt;
  logic                  u_wr_ren;
  logic                  u_wr_rok;

  logic                  u_rd_req;
  logic [LEN_WIDTH-1:0]  u_rd_len;
  logic [ADDR_WIDTH-1:0] u_rd_addr;
  logic                  u_rd_gnt;
  logic                  u_rd_wen;
  logic [DATA_WIDTH-1:0] u_rd_data;
  logic                  u_rd_wok;

  // Bridge view: slave to the core, master on the user ports.
  modport slave (
    input  c_req, c_we, c_funct3, c_addr, c_wdata,
    output c_ready, c_done, c_err, c_rdata,
    output u_wr_req, u_wr_len, u_wr_addr, u_wr_data, u_wr_strb, u_wr_rok,
    input  u_wr_gnt, u_wr_ren,
    output u_rd_req, u_rd_len, u_rd_addr, u_rd_wok,
    input  u_rd_gnt, u_rd_wen, u_rd_data
  );

  // Environment view: the core plus the wrapper behind the user ports.
  modport master (
    output c_req, c_we, c_funct3, c_addr, c_wdata,
    input  c_ready, c_done, c_err, c_rdata,
    input  u_wr_req, u_wr_len, u_wr_addr, u_wr_data, u_wr_strb, u_wr_rok,
    output u_wr_gnt, u_wr_ren,
    input  u_rd_req, u_rd_len, u_rd_addr, u_rd_wok,
    output u_rd_gnt, u_rd_wen, u_rd_data
  );
endinterface

// File: rtl/lsu_load_align.sv
// Combinational load extraction: picks the byte/half at addr[1:0] of a read
// word and sign- or zero-extends it according to funct3.
module lsu_load_align
  import rv32i_lsu_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  addr_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] result_o
);
  logic [31:0] shifted;

  always_comb begin
    shifted = word_i >> {addr_i, 3'b000};
    case (funct3_i)
      F3_LB:   result_o = {{24{shifted[7]}}, shifted[7:0]};
      F3_LH:   result_o = {{16{shifted[15]}}, shifted[15:0]};
      F3_LBU:  result_o = {24'd0, shifted[7:0]};
      F3_LHU:  result_o = {16'd0, shifted[15:0]};
      default: result_o = word_i;
    endcase
  end
endmodule

// File: rtl/lsu_axi_bridge.sv
// Single-access bridge from an RV32I load/store unit to single-beat user
// write/read ports; one access in flight, misaligned/illegal accesses rejected.
module lsu_axi_bridge
  import rv32i_lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 8,
  parameter int STRB_WIDTH = 4
) (
  input  logic             aclk,
  input  logic             aresetn,
  lsu_axi_bridge_if.slave  bus
);
  lsu_state_e            state_q, state_d;
  logic                  we_q, we_d;
  logic [2:0]            funct3_q, funct3_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  aw_done_q, aw_done_d;
  logic                  w_done_q, w_done_d;
  logic                  err_q, err_d;
  logic [31:0]           rdata_q, rdata_d;

  logic        accept;
  logic        aw_now, w_now;
  logic [3:0]  wr_strb;
  logic [31:0] wr_data;
  logic [31:0] load_res;

  lsu_load_align u_align (
    .word_i   (bus.u_rd_data),
    .addr_i   (addr_q[1:0]),
    .funct3_i (funct3_q),
    .result_o (load_res)
  );

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= ST_IDLE;
      we_q      <= 1'b0;
      funct3_q  <= 3'd0;
      addr_q    <= '0;
      wdata_q   <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= 32'd0;
    end else begin
      state_q   <= state_d;
      we_q      <= we_d;
      funct3_q  <= funct3_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
    end
  end

  assign accept = bus.c_req && (state_q == ST_IDLE);
  assign aw_now = aw_done_q || bus.u_wr_gnt;
  assign w_now  = w_done_q || bus.u_wr_ren;

  always_comb begin
    state_d   = state_q;
    we_d      = we_q;
    funct3_d  = funct3_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    err_d     = 1'b0;
    rdata_d   = rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          we_d      = bus.c_we;
          funct3_d  = bus.c_funct3;
          addr_d    = bus.c_addr;
          wdata_d   = bus.c_wdata;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          if (lsu_illegal(bus.c_we, bus.c_funct3, bus.c_addr[1:0])) err_d = 1'b1;
          else state_d = bus.c_we ? ST_WR : ST_RD_ADDR;
        end
      end
      ST_WR: begin
        // Grant and data acceptance are independent; finish when both have been seen.
        if (aw_now && w_now) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          rdata_d   = 32'd0;
          state_d   = ST_RESP;
        end else begin
          aw_done_d = aw_now;
          w_done_d  = w_now;
        end
      end
      ST_RD_ADDR: begin
        if (bus.u_rd_wen) begin
          rdata_d = load_res;
          state_d = ST_RESP;
        end else if (bus.u_rd_gnt) begin
          state_d = ST_RD_DATA;
        end
      end
      ST_RD_DATA: begin
        if (bus.u_rd_wen) begin
          rdata_d = load_res;
          state_d = ST_RESP;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    wr_strb = 4'b1111;
    wr_data = wdata_q;
    case (funct3_q[1:0])
      2'd0: begin
        wr_strb = 4'b0001 << addr_q[1:0];
        wr_data = {4{wdata_q[7:0]}};
      end
      2'd1: begin
        wr_strb = 4'b0011 << addr_q[1:0];
        wr_data = {2{wdata_q[15:0]}};
      end
      default: ;
    endcase
  end

  assign bus.c_ready   = (state_q == ST_IDLE);
  assign bus.c_done    = (state_q == ST_RESP);
  assign bus.c_err     = err_q;
  assign bus.c_rdata   = rdata_q;

  assign bus.u_wr_req  = (state_q == ST_WR) && !aw_done_q;
  assign bus.u_wr_rok  = (state_q == ST_WR) && !w_done_q;
  assign bus.u_wr_len  = LEN_WIDTH'(1);
  assign bus.u_wr_addr = {addr_q[ADDR_WIDTH-1:2], 2'b00};
  assign bus.u_wr_data = wr_data;
  assign bus.u_wr_strb = (state_q == ST_WR) ? STRB_WIDTH'(wr_strb) : '0;

  assign bus.u_rd_req  = (state_q == ST_RD_ADDR);
  assign bus.u_rd_wok  = (state_q == ST_RD_ADDR) || (state_q == ST_RD_DATA);
  assign bus.u_rd_len  = LEN_WIDTH'(1);
  assign bus.u_rd_addr = {addr_q[ADDR_WIDTH-1:2], 2'b00};
endmodule

// File: tb/tb_lsu_axi_bridge.sv
// Directed bench for lsu_axi_bridge: vector table of single accesses plus
// hand sequences for out-of-order write handshakes, late read beats and reset.
module tb_lsu_axi_bridge;
  import rv32i_lsu_pkg::*;

  logic aclk = 1'b0;
  logic aresetn;
  always #5 aclk = ~aclk;

  lsu_axi_bridge_if bus();

  lsu_axi_bridge dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .bus     (bus)
  );

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] beat;
    logic        err;
    logic [3:0]  strb;
    logic [31:0] wbus;
    logic [31:0] rdata;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs[NV];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge aclk);
  endtask

  task automatic clear_inputs();
    bus.c_req = 1'b0; bus.c_we = 1'b0; bus.c_funct3 = 3'd0;
    bus.c_addr = 32'd0; bus.c_wdata = 32'd0;
    bus.u_wr_gnt = 1'b0; bus.u_wr_ren = 1'b0;
    bus.u_rd_gnt = 1'b0; bus.u_rd_wen = 1'b0; bus.u_rd_data = 32'd0;
  endtask

  // Presents one request for a single cycle; returns at the negedge after acceptance.
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata);
    chk("c_ready before request", bus.c_ready, 32'd1);
    bus.c_req = 1'b1; bus.c_we = we; bus.c_funct3 = f3;
    bus.c_addr = addr; bus.c_wdata = wdata;
    tick();
    bus.c_req = 1'b0;
  endtask

  initial begin
    vec_t v;
    int   done_seen;

    vecs[0]  = '{1'b1, F3_SW,  32'h100, 32'hDEADBEEF, 32'h0, 1'b0, 4'b1111, 32'hDEADBEEF, 32'h0};
    vecs[1]  = '{1'b1, F3_SB,  32'h103, 32'h0000005A, 32'h0, 1'b0, 4'b1000, 32'h5A5A5A5A, 32'h0};
    vecs[2]  = '{1'b1, F3_SH,  32'h102, 32'h0000BEEF, 32'h0, 1'b0, 4'b1100, 32'hBEEFBEEF, 32'h0};
    vecs[3]  = '{1'b0, F3_LB,  32'h202, 32'h0, 32'h00F10000, 1'b0, 4'b0, 32'h0, 32'hFFFFFFF1};
    vecs[4]  = '{1'b0, F3_LBU, 32'h202, 32'h0, 32'h00F10000, 1'b0, 4'b0, 32'h0, 32'h000000F1};
    vecs[5]  = '{1'b0, F3_LH,  32'h302, 32'h0, 32'h80011234, 1'b0, 4'b0, 32'h0, 32'hFFFF8001};
    vecs[6]  = '{1'b0, F3_LHU, 32'h302, 32'h0, 32'h80011234, 1'b0, 4'b0, 32'h0, 32'h00008001};
    vecs[7]  = '{1'b0, F3_LW,  32'h400, 32'h0, 32'h12345678, 1'b0, 4'b0, 32'h0, 32'h12345678};
    vecs[8]  = '{1'b0, F3_LB,  32'h201, 32'h0, 32'h00007F00, 1'b0, 4'b0, 32'h0, 32'h0000007F};
    vecs[9]  = '{1'b0, F3_LH,  32'h301, 32'h0, 32'h0, 1'b1, 4'b0, 32'h0, 32'h0};
    vecs[10] = '{1'b1, F3_SW,  32'h102, 32'h1, 32'h0, 1'b1, 4'b0, 32'h0, 32'h0};
    vecs[11] = '{1'b1, 3'd4,   32'h100, 32'h1, 32'h0, 1'b1, 4'b0, 32'h0, 32'h0};
    vecs[12] = '{1'b0, 3'd3,   32'h000, 32'h0, 32'h0, 1'b1, 4'b0, 32'h0, 32'h0};
    vecs[13] = '{1'b0, F3_LW,  32'h402, 32'h0, 32'h0, 1'b1, 4'b0, 32'h0, 32'h0};

    clear_inputs();
    aresetn = 1'b0;
    #12;
    chk("reset c_ready", bus.c_ready, 32'd1);
    chk("reset c_done", bus.c_done, 32'd0);
    chk("reset c_err", bus.c_err, 32'd0);
    chk("reset c_rdata", bus.c_rdata, 32'd0);
    chk("reset u_wr_req", bus.u_wr_req, 32'd0);
    chk("reset u_rd_req", bus.u_rd_req, 32'd0);
    chk("reset u_wr_rok", bus.u_wr_rok, 32'd0);
    chk("reset u_rd_wok", bus.u_rd_wok, 32'd0);
    tick();
    aresetn = 1'b1;
    tick();

    for (int i = 0; i < NV; i++) begin
      v = vecs[i];
      issue(v.we, v.f3, v.addr, v.wdata);
      if (v.err) begin
        chk($sformatf("v%0d c_err pulse", i), bus.c_err, 32'd1);
        chk($sformatf("v%0d u_rd_req idle", i), bus.u_rd_req, 32'd0);
        chk($sformatf("v%0d u_wr_req idle", i), bus.u_wr_req, 32'd0);
        chk($sformatf("v%0d c_ready after err", i), bus.c_ready, 32'd1);
        tick();
        chk($sformatf("v%0d c_err one cycle", i), bus.c_err, 32'd0);
        chk($sformatf("v%0d no c_done", i), bus.c_done, 32'd0);
      end else if (v.we) begin
        chk($sformatf("v%0d u_wr_req", i), bus.u_wr_req, 32'd1);
        chk($sformatf("v%0d u_wr_rok", i), bus.u_wr_rok, 32'd1);
        chk($sformatf("v%0d u_wr_addr", i), bus.u_wr_addr, v.addr & 32'hFFFFFFFC);
        chk($sformatf("v%0d u_wr_strb", i), 32'(bus.u_wr_strb), 32'(v.strb));
        chk($sformatf("v%0d u_wr_data", i), bus.u_wr_data, v.wbus);
        chk($sformatf("v%0d u_wr_len", i), 32'(bus.u_wr_len), 32'd1);
        bus.u_wr_gnt = 1'b1; bus.u_wr_ren = 1'b1;
        tick();
        bus.u_wr_gnt = 1'b0; bus.u_wr_ren = 1'b0;
        chk($sformatf("v%0d c_done", i), bus.c_done, 32'd1);
        chk($sformatf("v%0d store c_rdata", i), bus.c_rdata, 32'd0);
        chk($sformatf("v%0d u_wr_req dropped", i), bus.u_wr_req, 32'd0);
        tick();
        chk($sformatf("v%0d c_done one cycle", i), bus.c_done, 32'd0);
      end else begin
        chk($sformatf("v%0d u_rd_req", i), bus.u_rd_req, 32'd1);
        chk($sformatf("v%0d u_rd_wok", i), bus.u_rd_wok, 32'd1);
        chk($sformatf("v%0d u_rd_addr", i), bus.u_rd_addr, v.addr & 32'hFFFFFFFC);
        chk($sformatf("v%0d u_rd_len", i), 32'(bus.u_rd_len), 32'd1);
        bus.u_rd_gnt = 1'b1; bus.u_rd_wen = 1'b1; bus.u_rd_data = v.beat;
        tick();
        bus.u_rd_gnt = 1'b0; bus.u_rd_wen = 1'b0; bus.u_rd_data = 32'd0;
        chk($sformatf("v%0d c_done", i), bus.c_done, 32'd1);
        chk($sformatf("v%0d c_rdata", i), bus.c_rdata, v.rdata);
        tick();
        chk($sformatf("v%0d c_done one cycle", i), bus.c_done, 32'd0);
        chk($sformatf("v%0d c_rdata held", i), bus.c_rdata, v.rdata);
      end
    end

    // Write data accepted two cycles before the address grant.
    issue(1'b1, F3_SB, 32'h103, 32'h0000005A);
    chk("early-data strb", 32'(bus.u_wr_strb), 32'h8);
    chk("early-data data", bus.u_wr_data, 32'h5A5A5A5A);
    bus.u_wr_ren = 1'b1;
    tick();
    bus.u_wr_ren = 1'b0;
    chk("early-data rok dropped", bus.u_wr_rok, 32'd0);
    chk("early-data req held", bus.u_wr_req, 32'd1);
    chk("early-data no done", bus.c_done, 32'd0);
    tick();
    chk("early-data req still held", bus.u_wr_req, 32'd1);
    bus.u_wr_gnt = 1'b1;
    tick();
    bus.u_wr_gnt = 1'b0;
    chk("early-data done after gnt", bus.c_done, 32'd1);
    tick();

    // Address grant before write data acceptance.
    issue(1'b1, F3_SH, 32'h106, 32'h00001234);
    chk("early-gnt strb", 32'(bus.u_wr_strb), 32'hC);
    chk("early-gnt data", bus.u_wr_data, 32'h12341234);
    chk("early-gnt addr", bus.u_wr_addr, 32'h104);
    bus.u_wr_gnt = 1'b1;
    tick();
    bus.u_wr_gnt = 1'b0;
    chk("early-gnt req dropped", bus.u_wr_req, 32'd0);
    chk("early-gnt rok held", bus.u_wr_rok, 32'd1);
    chk("early-gnt no done", bus.c_done, 32'd0);
    bus.u_wr_ren = 1'b1;
    tick();
    bus.u_wr_ren = 1'b0;
    chk("early-gnt done", bus.c_done, 32'd1);
    tick();

    // Read beat arriving two cycles after the grant.
    issue(1'b0, F3_LW, 32'h600, 32'h0);
    bus.u_rd_gnt = 1'b1;
    tick();
    bus.u_rd_gnt = 1'b0;
    chk("late-beat req dropped", bus.u_rd_req, 32'd0);
    chk("late-beat wok held", bus.u_rd_wok, 32'd1);
    tick();
    chk("late-beat no done yet", bus.c_done, 32'd0);
    bus.u_rd_wen = 1'b1; bus.u_rd_data = 32'hCAFEF00D;
    tick();
    bus.u_rd_wen = 1'b0; bus.u_rd_data = 32'd0;
    chk("late-beat done", bus.c_done, 32'd1);
    chk("late-beat rdata", bus.c_rdata, 32'hCAFEF00D);
    tick();

    // Reset while waiting for a read beat.
    issue(1'b0, F3_LW, 32'h700, 32'h0);
    bus.u_rd_gnt = 1'b1;
    tick();
    bus.u_rd_gnt = 1'b0;
    chk("pre-reset wok", bus.u_rd_wok, 32'd1);
    chk("pre-reset rdata", bus.c_rdata, 32'hCAFEF00D);
    #2 aresetn = 1'b0;
    #1;
    chk("mid-reset c_done", bus.c_done, 32'd0);
    chk("mid-reset c_err", bus.c_err, 32'd0);
    chk("mid-reset u_rd_wok", bus.u_rd_wok, 32'd0);
    chk("mid-reset u_rd_req", bus.u_rd_req, 32'd0);
    chk("mid-reset u_wr_req", bus.u_wr_req, 32'd0);
    chk("mid-reset u_wr_rok", bus.u_wr_rok, 32'd0);
    chk("mid-reset c_rdata", bus.c_rdata, 32'd0);
    tick();
    aresetn = 1'b1;
    chk("post-reset c_ready", bus.c_ready, 32'd1);
    bus.u_rd_wen = 1'b1; bus.u_rd_data = 32'h11111111;
    done_seen = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (bus.c_done) done_seen++;
    end
    bus.u_rd_wen = 1'b0;
    chk("post-reset no c_done", 32'(done_seen), 32'd0);
    chk("post-reset rdata untouched", bus.c_rdata, 32'd0);
    chk("post-reset still idle", bus.c_ready, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/lsu_axi_bridge.md
LSU_AXI_BRIDGE -- requirements
Module: lsu_axi_bridge

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, byte address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, bus data width; only 32 is supported.
REQ-003 SHALL have parameter LEN_WIDTH, default 8, width of the u_wr_len/u_rd_len fields.
REQ-004 SHALL have parameter STRB_WIDTH, default 4, DATA_WIDTH/8.
REQ-005 SHALL have the following ports:
- aclk  in  1  clock.
- aresetn  in  1  reset, asynchronous, active-low.
- c_req  in  1  core access request.
- c_we  in  1  1 = store, 0 = load.
- c_funct3  in  3  RV32I size/sign code.
- c_addr  in  ADDR_WIDTH  byte address.
- c_wdata  in  DATA_WIDTH  store data, right-aligned.
- c_ready  out  1  bridge accepts the request this cycle.
- c_done  out  1  one-cycle completion pulse.
- c_err  out  1  one-cycle misaligned or illegal pulse.
- c_rdata  out  DATA_WIDTH  load result, valid with c_done.
- u_wr_req, u_wr_len, u_wr_addr, u_wr_data, u_wr_strb  out  1/LEN/ADDR/DATA/STRB  write user port.
- u_wr_gnt, u_wr_ren  in  1  write address granted, write data accepted.
- u_wr_rok  out  1  data-available flag to the wrapper.
- u_rd_req, u_rd_len, u_rd_addr  out  1/LEN/ADDR  read user port.
- u_rd_gnt  in  1  read address granted.
- u_rd_wen  in  1  read beat strobe.
- u_rd_data  in  DATA_WIDTH  read beat data.
- u_rd_wok  out  1  ready to take a read beat.

Function
REQ-006 SHALL implement an FSM with states IDLE, WR, RD_ADDR, RD_DATA and RESP.
REQ-007 SHALL drive c_ready=1 only in IDLE.
REQ-008 SHALL treat c_req&c_ready as acceptance and capture c_we, c_funct3, c_addr and c_wdata into registers on that cycle.
REQ-009 SHALL flag an illegal access at acceptance in these cases:
- Store with funct3 other than 0, 1 or 2.
- Load with funct3 equal to 3, 6 or 7.
- Halfword access with addr[0]=1.
- Word access with addr[1:0]≠0.
REQ-010 SHALL handle an illegal access by pulsing c_err the next cycle and remaining in IDLE, with no u_* request issued.
REQ-011 SHALL move a legal store to WR and a legal load to RD_ADDR on the cycle after acceptance.
REQ-012 SHALL drive u_wr_addr and u_rd_addr as {addr[ADDR_WIDTH-1:2],2'b00}.
REQ-013 SHALL drive u_wr_len=1 and u_rd_len=1.
REQ-014 SHALL generate store strobes and data as follows:
- SB: strb=4'b0001<<addr[1:0], data={4{wdata[7:0]}}.
- SH: strb=4'b0011<<addr[1:0], data={2{wdata[15:0]}}.
- SW: strb=4'b1111, data=wdata.
REQ-015 SHALL, in WR, hold u_wr_req=1 until u_wr_gnt has been seen, then drive it 0.
REQ-016 SHALL keep sticky flags aw_done and w_done; u_wr_gnt and u_wr_ren may occur in any order or in the same cycle.
REQ-017 SHALL leave WR for RESP in the cycle where both flags, including same-cycle inputs, are set.
REQ-018 SHALL drive u_wr_rok=1 in WR while w_done=0.
REQ-019 SHALL, in RD_ADDR, drive u_rd_req=1 until u_rd_gnt, then move to RD_DATA.
REQ-020 SHALL drive u_rd_wok=1 in RD_ADDR and RD_DATA, so a beat arriving with the grant is accepted.
REQ-021 SHALL, on u_rd_wen, capture the extracted load result and go to RESP; this may happen directly from RD_ADDR.
REQ-022 SHALL extract the load result by selecting the byte/half at addr[1:0]:
- LB and LH: sign-extend.
- LBU and LHU: zero-extend.
- LW: full word.
REQ-023 SHALL, in RESP, pulse c_done=1 for one cycle with c_rdata valid (0 for stores), then return to IDLE.
REQ-024 SHALL complete a store with immediate grant and accept in 3 cycles: accept T, u_wr_req at T+1, c_done at T+2.
REQ-025 SHALL keep c_rdata stable until the next c_done.
REQ-026 SHALL drive u_wr_req and u_rd_req 0 outside WR and RD_ADDR.
REQ-027 SHALL ignore u_rd_wen outside RD_ADDR and RD_DATA.

Reset
REQ-028 SHALL, with aresetn=0, asynchronously force:
- FSM to IDLE.
- All flags and registers to 0.
- c_done, c_err, u_wr_req, u_rd_req, u_wr_rok, u_rd_wok and c_rdata to 0.
REQ-029 SHALL, on reset mid-transaction, abandon the transaction, emit no c_done after release, and present c_ready=1 in the first cycle after release.

Structure
REQ-030 SHALL take the funct3 encodings (LB=0, LH=1, LW=2, LBU=4, LHU=5, SB=0, SH=1, SW=2) and the FSM state encoding from a shared package, rv32i_lsu_pkg.
REQ-031 SHALL place load extraction in combinational sub-module lsu_load_align (inputs word, addr[1:0], funct3; output 32-bit result).

Verification
REQ-032 SHALL cover: SW addr 0x100, data 0xDEADBEEF, grant and accept the cycle after acceptance -> u_wr_strb=4'hF, u_wr_addr=0x100, c_done 2 cycles after accept.
REQ-033 SHALL cover: SB addr 0x103, data 0x5A, u_wr_ren 2 cycles before u_wr_gnt -> strb=4'b1000, data=0x5A5A5A5A, c_done the cycle after u_wr_gnt.
REQ-034 SHALL cover: LB addr 0x202, beat 0x00F10000 -> c_rdata=0xFFFFFFF1; LBU at the same address -> c_rdata=0x000000F1.
REQ-035 SHALL cover: LH addr 0x301 -> c_err pulse; u_rd_req never asserted; c_ready=1 the following cycle.
REQ-036 SHALL cover: LW with u_rd_gnt and u_rd_wen in the same cycle, data 0x12345678 -> c_rdata=0x12345678, c_done the next cycle.
REQ-037 SHALL cover: aresetn low while in RD_DATA -> all outputs 0 immediately; no c_done after release.
